// File: rtl/shift_unit_if.sv
// Request/response bundle between an ALU issue stage and the shift unit.
// Latency: none (wires only).
// Backpressure: requester holds off start until ready; done is a single-cycle pulse.
interface shift_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, A, B,
      input  ready, done, result
   );

   modport slave (
      input  start, op, A, B,
      output ready, done, result
   );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit: SHR, SHRA, SHL, ROR, ROL, STEP bit positions per clock.
// Latency: ceil(cnt/STEP)+1 cycles from accepting start to the done pulse (cnt=0 gives 1).
// Backpressure: ready is low while busy; start is ignored, not queued, when ready is low.
module shift_unit #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input logic          clock,
   input logic          clear,
   shift_unit_if.slave  bus
);

   localparam int LW = $clog2(WIDTH);
   localparam int CW = LW + 1;   // counter must be able to hold WIDTH itself

   localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
   localparam logic [CW-1:0]    STEP_C  = CW'(STEP);
   localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);

   localparam logic [2:0] OP_SHR  = 3'b000;
   localparam logic [2:0] OP_SHRA = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work, work_nxt;
   logic [CW-1:0]    cnt, cnt_nxt, load_cnt;
   logic [2:0]       op_q, op_nxt;
   logic             sign_q, sign_nxt;
   logic [WIDTH-1:0] result_q, result_nxt;
   logic             ready_q, done_q;

   logic [CW-1:0]    s;
   logic [CW-1:0]    inv;
   logic [WIDTH-1:0] shifted;

   assign bus.ready  = ready_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

   // One iteration of the datapath: shift the work register by min(STEP, cnt).
   always_comb begin
      s       = (cnt < STEP_C) ? cnt : STEP_C;
      inv     = WIDTH_C - s;   // complementary amount for wrap-around / sign fill
      shifted = work;
      case (op_q)
         OP_SHR:  shifted = work >> s;
         OP_SHRA: shifted = (work >> s) | ({WIDTH{sign_q}} << inv);
         OP_SHL:  shifted = work << s;
         OP_ROR:  shifted = (work >> s) | (work << inv);
         OP_ROL:  shifted = (work << s) | (work >> inv);
         default: shifted = work;
      endcase
   end

   // Initial remaining count: shifts saturate at WIDTH over the full B, rotates wrap modulo WIDTH.
   always_comb begin
      load_cnt = '0;
      case (bus.op)
         OP_SHR, OP_SHRA, OP_SHL:
            load_cnt = (bus.B >= WIDTH_W) ? WIDTH_C : bus.B[CW-1:0];
         OP_ROR, OP_ROL:
            load_cnt = {1'b0, bus.B[LW-1:0]};
         default:
            load_cnt = '0;   // invalid op passes A through unchanged
      endcase
   end

   // Next-state and next-datapath values; result is captured on the transition into DONE.
   always_comb begin
      state_nxt  = state;
      work_nxt   = work;
      cnt_nxt    = cnt;
      op_nxt     = op_q;
      sign_nxt   = sign_q;
      result_nxt = result_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               work_nxt = bus.A;
               op_nxt   = bus.op;
               sign_nxt = bus.A[WIDTH-1];
               cnt_nxt  = load_cnt;
               if (load_cnt == '0) begin
                  state_nxt  = DONE;
                  result_nxt = bus.A;
               end else begin
                  state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            work_nxt = shifted;
            cnt_nxt  = cnt - s;
            if (cnt - s == '0) begin
               state_nxt  = DONE;
               result_nxt = shifted;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers; ready/done are registered from the next state.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state    <= IDLE;
         work     <= '0;
         cnt      <= '0;
         op_q     <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         work     <= work_nxt;
         cnt      <= cnt_nxt;
         op_q     <= op_nxt;
         sign_q   <= sign_nxt;
         result_q <= result_nxt;
         ready_q  <= (state_nxt == IDLE);
         done_q   <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: STEP=1 and STEP=8 instances driven with identical requests.
// Latency: expected done cycle derived per instance from the request.
// Backpressure: requests are issued only when both instances report ready.
module tb_shift_unit;

   logic clock;
   logic clear;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;

   int cyc;
   int checks;
   int failures;
   int done_cnt1;
   int done_cnt8;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q8[$];
   exp_t e1, e8;
   logic [31:0] last1, last8;
   bit after1, after8;

   shift_unit_if #(.WIDTH(32)) bus1 ();
   shift_unit_if #(.WIDTH(32)) bus8 ();

   assign bus1.start = start;
   assign bus1.op    = op;
   assign bus1.A     = a;
   assign bus1.B     = b;
   assign bus8.start = start;
   assign bus8.op    = op;
   assign bus8.A     = a;
   assign bus8.B     = b;

   shift_unit #(.WIDTH(32), .STEP(1)) dut1 (.clock(clock), .clear(clear), .bus(bus1));
   shift_unit #(.WIDTH(32), .STEP(8)) dut8 (.clock(clock), .clear(clear), .bus(bus8));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: result straight from the operation definition.
   function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int r;
      r = int'(y % 32);
      case (o)
         3'd0: return (y >= 32) ? 32'h0 : x >> y;
         3'd1: return (y >= 32) ? {32{x[31]}} : 32'($signed(x) >>> y);
         3'd2: return (y >= 32) ? 32'h0 : x << y;
         3'd3: return (r == 0) ? x : ((x >> r) | (x << (32 - r)));
         3'd4: return (r == 0) ? x : ((x << r) | (x >> (32 - r)));
         default: return x;
      endcase
   endfunction

   // Reference: number of bit positions the unit has to walk through.
   function automatic int model_cnt(input logic [2:0] o, input logic [31:0] y);
      if (o <= 3'd2) return (y >= 32) ? 32 : int'(y);
      if (o <= 3'd4) return int'(y % 32);
      return 0;
   endfunction

   // Monitor for the STEP=1 instance.
   always @(negedge clock) begin
      if (after1) begin
         chk("ready_back1", 32'(bus1.ready), 32'd1);
         chk("done_pulse1", 32'(bus1.done), 32'd0);
         chk("result_held1", bus1.result, last1);
         after1 = 1'b0;
      end
      if (bus1.done === 1'b1) begin
         done_cnt1++;
         if (q1.size() == 0) begin
            chk("unexpected_done1", 32'd1, 32'd0);
         end else begin
            e1 = q1.pop_front();
            chk("result1", bus1.result, e1.res);
            chk("latency1", 32'(cyc), 32'(e1.cyc));
            chk("ready_low1", 32'(bus1.ready), 32'd0);
            last1  = e1.res;
            after1 = 1'b1;
         end
      end
   end

   // Monitor for the STEP=8 instance.
   always @(negedge clock) begin
      if (after8) begin
         chk("ready_back8", 32'(bus8.ready), 32'd1);
         chk("done_pulse8", 32'(bus8.done), 32'd0);
         chk("result_held8", bus8.result, last8);
         after8 = 1'b0;
      end
      if (bus8.done === 1'b1) begin
         done_cnt8++;
         if (q8.size() == 0) begin
            chk("unexpected_done8", 32'd1, 32'd0);
         end else begin
            e8 = q8.pop_front();
            chk("result8", bus8.result, e8.res);
            chk("latency8", 32'(cyc), 32'(e8.cyc));
            chk("ready_low8", 32'(bus8.ready), 32'd0);
            last8  = e8.res;
            after8 = 1'b1;
         end
      end
   end

   // Issue one request once both units are idle; optionally pulse start while they are busy.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit spur);
      int guard;
      int k;
      int c;
      exp_t en;
      guard = 0;
      @(negedge clock);
      while (!(bus1.ready === 1'b1 && bus8.ready === 1'b1) && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 200) chk("wait_ready_timeout", 32'd1, 32'd0);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      k     = cyc + 1;
      c     = model_cnt(o, y);
      en.res = model_res(o, x, y);
      en.cyc = k + c;
      q1.push_back(en);
      en.cyc = k + (c + 7) / 8;
      q8.push_back(en);
      @(negedge clock);
      if (spur) begin
         start = 1'b1;
         op    = 3'($urandom_range(0, 4));
         a     = $urandom;
         b     = $urandom_range(1, 31);
         @(negedge clock);
         if (c > 0) @(negedge clock);
      end
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   logic [2:0]  dir_op [13] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd3, 3'd4, 3'd4,
                               3'd7, 3'd2, 3'd0, 3'd1, 3'd3, 3'd4};
   logic [31:0] dir_a  [13] = '{32'hF000_000F, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'h0000_0001, 32'h8000_0001, 32'hDEAD_BEEF, 32'h1234_5678,
                               32'h0000_00FF, 32'hA5A5_0F0F, 32'h9000_0001, 32'h7000_000E,
                               32'hC3C3_1234};
   logic [31:0] dir_b  [13] = '{32'd4, 32'd31, 32'd40, 32'h0001_0000, 32'd33, 32'd4, 32'd64,
                               32'd5, 32'd20, 32'd0, 32'd0, 32'd0, 32'd0};

   initial begin
      int guard;
      int d1, d8;
      logic [31:0] rb;
      cyc = 0; checks = 0; failures = 0; done_cnt1 = 0; done_cnt8 = 0;
      after1 = 1'b0; after8 = 1'b0; last1 = '0; last8 = '0;
      clear = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;

      repeat (3) @(negedge clock);
      chk("rst_ready1", 32'(bus1.ready), 32'd1);
      chk("rst_done1", 32'(bus1.done), 32'd0);
      chk("rst_result1", bus1.result, 32'd0);
      chk("rst_ready8", 32'(bus8.ready), 32'd1);
      chk("rst_done8", 32'(bus8.done), 32'd0);
      chk("rst_result8", bus8.result, 32'd0);
      clear = 1'b1;

      for (int i = 0; i < 13; i++) issue(dir_op[i], dir_a[i], dir_b[i], (i % 2) == 1);
      issue(3'd2, 32'hFFFF_FFFF, 32'd0, 1'b1);

      // Abort an in-flight operation: state clears and no done follows.
      issue(3'd1, 32'h8000_0000, 32'd31, 1'b0);
      @(negedge clock);
      clear = 1'b0;
      q1.delete();
      q8.delete();
      d1 = done_cnt1;
      d8 = done_cnt8;
      @(negedge clock);
      clear = 1'b1;
      chk("abort_ready1", 32'(bus1.ready), 32'd1);
      chk("abort_done1", 32'(bus1.done), 32'd0);
      chk("abort_result1", bus1.result, 32'd0);
      chk("abort_ready8", 32'(bus8.ready), 32'd1);
      chk("abort_done8", 32'(bus8.done), 32'd0);
      chk("abort_result8", bus8.result, 32'd0);
      last1 = '0;
      last8 = '0;
      repeat (40) @(negedge clock);
      chk("abort_no_done1", 32'(done_cnt1), 32'(d1));
      chk("abort_no_done8", 32'(done_cnt8), 32'(d8));

      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 3))
            0: rb = $urandom_range(0, 40);
            1: rb = $urandom;
            2: rb = 32 * $urandom_range(0, 4);
            default: rb = 32'd1 << $urandom_range(0, 31);
         endcase
         issue(3'($urandom_range(0, 7)), $urandom, rb, $urandom_range(0, 3) == 0);
      end

      guard = 0;
      while ((q1.size() != 0 || q8.size() != 0) && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      chk("drain_q1", 32'(q1.size()), 32'd0);
      chk("drain_q8", 32'(q8.size()), 32'd0);
      @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
